// File: rtl/norm_shift16.sv
// -----------------------------------------------------------------------------
// norm_shift16
//
// Iterative left-shift normalizer for the 16-bit fixed-point CORDIC datapath.
// A signed two's-complement operand is shifted left, one or two bits per
// cycle, until its two most significant bits differ. Only redundant sign bits
// are shifted out, so the sign of the operand is always preserved. The block
// reports the normalized word and the total shift applied. An all-zero
// operand cannot be normalized and is flagged with zero=1.
//
// Configuration macro:
//   NORM_SHIFT2_EN  When defined, a 2-bit step is taken whenever the top three
//                   bits are equal. Results are identical in both builds; only
//                   the number of cycles differs.
//
// Parameters:
//   WIDTH    datapath width in bits (WIDTH >= 4)
//   SW       width of the shift-count output
//
// Ports:
//   clk      in   rising-edge clock
//   reset_b  in   asynchronous active-low reset
//   start    in   load request, sampled only when not busy
//   a        in   signed operand, captured on an accepted start
//   busy     out  high while shifting is in progress
//   done     out  one-cycle pulse when the result is valid
//   dataout  out  normalized word, held until the next done
//   shamt    out  total left-shift applied to a
//   zero     out  operand was zero
// -----------------------------------------------------------------------------
module norm_shift16 #(
  parameter int WIDTH = 16,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataout,
  output logic [SW-1:0]    shamt,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] w_work_nxt;
  logic [SW-1:0]    r_count;
  logic [SW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] r_dataout;
  logic [WIDTH-1:0] w_dataout_nxt;
  logic [SW-1:0]    r_shamt;
  logic [SW-1:0]    w_shamt_nxt;
  logic             r_zero;
  logic             w_zero_nxt;

  logic             w_is_zero;
  logic             w_normalized;
  logic             w_can_shift2;

  // Status of the working register, evaluated every SHIFT cycle.
  assign w_is_zero    = (r_work == '0);
  assign w_normalized = r_work[WIDTH-1] ^ r_work[WIDTH-2];

`ifdef NORM_SHIFT2_EN
  // A 2-bit step is only safe when at least two redundant sign bits exist
  // (top three bits equal) and the running count stays within WIDTH-1.
  // Comparing against WIDTH-3 avoids overflowing the SW-bit count in count+2.
  localparam logic [SW-1:0] CNT2_MAX = SW'(WIDTH - 3);

  assign w_can_shift2 = (r_work[WIDTH-1] == r_work[WIDTH-2]) &&
                        (r_work[WIDTH-2] == r_work[WIDTH-3]) &&
                        (r_count <= CNT2_MAX);
`else
  assign w_can_shift2 = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned, which would infer a latch.
    w_state_nxt   = r_state;
    w_work_nxt    = r_work;
    w_count_nxt   = r_count;
    w_dataout_nxt = r_dataout;
    w_shamt_nxt   = r_shamt;
    w_zero_nxt    = r_zero;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_work_nxt  = a;
          w_count_nxt = '0;
          w_state_nxt = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (w_is_zero) begin
          w_dataout_nxt = '0;
          w_shamt_nxt   = '0;
          w_zero_nxt    = 1'b1;
          w_state_nxt   = S_DONE;
        end else if (w_normalized) begin
          // Detect cycle: publish the result, no shift this cycle.
          w_dataout_nxt = r_work;
          w_shamt_nxt   = r_count;
          w_zero_nxt    = 1'b0;
          w_state_nxt   = S_DONE;
        end else if (w_can_shift2) begin
          w_work_nxt  = {r_work[WIDTH-3:0], 2'b00};
          w_count_nxt = r_count + SW'(2);
        end else begin
          w_work_nxt  = {r_work[WIDTH-2:0], 1'b0};
          w_count_nxt = r_count + SW'(1);
        end
      end

      S_DONE: begin
        // A start here is accepted directly, so back-to-back operations
        // run without an idle bubble.
        if (start) begin
          w_work_nxt  = a;
          w_count_nxt = '0;
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_b) begin
    // NOTE: the working register and count are plain flops rather than a
    // memory, so they are reset along with the rest; an abort then leaves
    // nothing stale behind.
    if (!reset_b) begin
      r_state   <= S_IDLE;
      r_work    <= '0;
      r_count   <= '0;
      r_dataout <= '0;
      r_shamt   <= '0;
      r_zero    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge.
      r_state   <= w_state_nxt;
      r_work    <= w_work_nxt;
      r_count   <= w_count_nxt;
      r_dataout <= w_dataout_nxt;
      r_shamt   <= w_shamt_nxt;
      r_zero    <= w_zero_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy    = (r_state == S_SHIFT);
  assign done    = (r_state == S_DONE);
  assign dataout = r_dataout;
  assign shamt   = r_shamt;
  assign zero    = r_zero;

endmodule

// File: tb/tb_norm_shift16.sv
// -----------------------------------------------------------------------------
// tb_norm_shift16
//
// Self-checking bench for norm_shift16 (WIDTH=16). A reference model derives
// each result from the count of redundant sign bits of the operand and the
// number of steps from that count, then a compare process checks busy, done
// and the result outputs every cycle. Directed operations additionally check
// hand-computed results and latencies.
// Honours NORM_SHIFT2_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_norm_shift16;

  localparam int W = 16;

`ifdef NORM_SHIFT2_EN
  localparam bit SHIFT2 = 1'b1;
`else
  localparam bit SHIFT2 = 1'b0;
`endif

  logic          clk;
  logic          reset_b;
  logic          start;
  logic [W-1:0]  a;
  logic          busy;
  logic          done;
  logic [W-1:0]  dataout;
  logic [3:0]    shamt;
  logic          zero;

  int total = 0;
  int bad   = 0;

  norm_shift16 #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .start   (start),
    .a       (a),
    .busy    (busy),
    .done    (done),
    .dataout (dataout),
    .shamt   (shamt),
    .zero    (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // Result: shift out every bit below the sign that merely repeats the sign.
  function automatic void ref_norm(input logic [W-1:0] v, output logic [W-1:0] d,
                                   output int l, output logic z);
    z = (v == '0);
    l = 0;
    if (!z)
      while (l < W - 1 && v[W-2-l] == v[W-1]) l++;
    d = z ? '0 : (v << l);
  endfunction

  // Steps: 2-bit steps cover the redundant bits in pairs, 1-bit otherwise.
  function automatic int ref_steps(input int l, input logic z);
    if (z) return 0;
    return SHIFT2 ? (l + 1) / 2 : l;
  endfunction

  int           m_wait = 0;     // edges until the result becomes visible
  logic         m_done = 1'b0;
  logic [W-1:0] m_data = '0;
  logic [3:0]   m_sh   = '0;
  logic         m_zero = 1'b0;
  logic [W-1:0] p_data;
  logic [3:0]   p_sh;
  logic         p_zero;

  always @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      m_wait = 0;
      m_done = 1'b0;
      m_data = '0;
      m_sh   = '0;
      m_zero = 1'b0;
    end else if (m_wait != 0) begin
      m_wait = m_wait - 1;
      m_done = (m_wait == 0);
      if (m_wait == 0) begin
        m_data = p_data;
        m_sh   = p_sh;
        m_zero = p_zero;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        logic [W-1:0] d;
        int           l;
        logic         z;
        ref_norm(a, d, l, z);
        p_data = d;
        p_sh   = 4'(l);
        p_zero = z;
        m_wait = ref_steps(l, z) + 1;
      end
    end
  end

  // Compare process: all outputs are meaningful on every cycle.
  always @(negedge clk) begin
    check("cmp_busy",    32'(busy),    32'(m_wait != 0));
    check("cmp_done",    32'(done),    32'(m_done));
    check("cmp_dataout", 32'(dataout), 32'(m_data));
    check("cmp_shamt",   32'(shamt),   32'(m_sh));
    check("cmp_zero",    32'(zero),    32'(m_zero));
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  // Called just after the edge that samples start. Waits (bounded) for done,
  // optionally pulsing an extra start with a=0x0003 while busy, then checks
  // the hand-computed result and latency in edges from the sampling edge.
  task automatic wait_result(input string nm, input logic [W-1:0] xd, input logic [3:0] xs,
                             input logic xz, input int xlat, input int poke);
    int lat;
    bit got;
    lat = 1;
    got = 1'b0;
    #2 start = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        @(posedge clk);
        lat++;
        #2;
        start = (lat == poke);
        if (lat == poke) a = 16'h0003;
      end
    end
    check({nm, "_done_seen"}, 32'(got), 32'd1);
    check({nm, "_latency"},   32'(lat), 32'(xlat));
    check({nm, "_dataout"},   32'(dataout), 32'(xd));
    check({nm, "_shamt"},     32'(shamt), 32'(xs));
    check({nm, "_zero"},      32'(zero), 32'(xz));
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] xd,
                        input logic [3:0] xs, input logic xz, input int xlat, input int poke);
    @(posedge clk);
    #2;
    start = 1'b1;
    a     = av;
    @(posedge clk);
    wait_result(nm, xd, xs, xz, xlat, poke);
  endtask

  initial begin
    reset_b = 1'b0;
    start   = 1'b0;
    a       = '0;

    // Reset held with start toggling: nothing may start.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #2;
      start = ~start;
      a     = 16'h0001;
    end
    @(negedge clk);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_dataout", 32'(dataout), 32'd0);
    check("rst_shamt",   32'(shamt),   32'd0);
    check("rst_zero",    32'(zero),    32'd0);
    @(posedge clk);
    #2;
    start   = 1'b0;
    reset_b = 1'b1;

    run_op("norm4000", 16'h4000, 16'h4000, 4'd0,  1'b0, 2, 0);
    run_op("pos0001",  16'h0001, 16'h4000, 4'd14, 1'b0, SHIFT2 ? 9 : 16, 0);
    run_op("negFFFF",  16'hFFFF, 16'h8000, 4'd15, 1'b0, SHIFT2 ? 10 : 17, 0);
    run_op("negE000",  16'hE000, 16'h8000, 4'd2,  1'b0, SHIFT2 ? 3 : 4, 0);
    run_op("pos2000",  16'h2000, 16'h4000, 4'd1,  1'b0, 3, 0);
    run_op("zero",     16'h0000, 16'h0000, 4'd0,  1'b1, 2, 0);
    run_op("clrzero",  16'h4000, 16'h4000, 4'd0,  1'b0, 2, 0);
    run_op("negC123",  16'hC123, 16'h8246, 4'd1,  1'b0, 3, 0);

    // start pulsed with a=0x0003 while busy: ignored.
    run_op("ignore",   16'h0001, 16'h4000, 4'd14, 1'b0, SHIFT2 ? 9 : 16, 3);

    // Back-to-back: start raised during the DONE cycle of the previous op.
    run_op("b2b_first", 16'h2000, 16'h4000, 4'd1, 1'b0, 3, 0);
    start = 1'b1;
    a     = 16'h0100;
    @(posedge clk);
    wait_result("b2b_second", 16'h4000, 4'd6, 1'b0, SHIFT2 ? 5 : 8, 0);

    // Abort during SHIFT.
    @(posedge clk);
    #2;
    start = 1'b1;
    a     = 16'h0001;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_b = 1'b0;
    @(negedge clk);
    check("abort_busy",    32'(busy),    32'd0);
    check("abort_done",    32'(done),    32'd0);
    check("abort_dataout", 32'(dataout), 32'd0);
    check("abort_shamt",   32'(shamt),   32'd0);
    check("abort_zero",    32'(zero),    32'd0);
    @(posedge clk);
    #2;
    reset_b = 1'b1;
    run_op("after_abort", 16'h0100, 16'h4000, 4'd6, 1'b0, SHIFT2 ? 5 : 8, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
